uart_rx: RTL and testbench

Asynchronous serial receiver for the eelab UART link. It recovers 8-bit frames (1 start, 8 data LSB-first, 1 stop) from the serial line `rxd` and presents each byte on a parallel bus with a one-cycle valid strobe. It is the receive-side counterpart of the lab transmitter, which shifts the byte out LSB-first on `txd`, and sits between the board RX pin and the user logic.

---
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with one-cycle valid/ferr strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit and the perr strobe.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       valid,
    output logic       ferr,
    output logic       perr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic [1:0] sync;
    logic rs;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] sh, sh_n, dout_n;
    logic armed, armed_n, valid_n, ferr_n;
    assign rs = sync[1];
`ifdef UART_RX_PARITY_EN
    logic par, par_n, perr_n;
`endif
    always_comb begin
        state_n = state;
        cnt_n = cnt + CW'(1);
        idx_n = idx;
        sh_n = sh;
        armed_n = armed;
        dout_n = dout;
        valid_n = 1'b0;
        ferr_n = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n = par;
        perr_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                armed_n = armed ? rs : rs;
                if (armed && !rs) state_n = START;
            end
            START: if (cnt == MID) begin
                cnt_n = '0;
                idx_n = '0;
                state_n = rs ? IDLE : DATA;
            end
            DATA: if (cnt == LAST) begin
                cnt_n = '0;
                sh_n = {rs, sh[7:1]};
                idx_n = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (idx == 3'd7) state_n = PARITY;
`else
                if (idx == 3'd7) state_n = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt == LAST) begin
                cnt_n = '0;
                par_n = ^{rs, sh};
                state_n = STOP;
            end
`endif
            STOP: if (cnt == LAST) begin
                // a low stop bit leaves armed clear so a held break cannot retrigger
                cnt_n = '0;
                state_n = IDLE;
                armed_n = rs;
                valid_n = rs;
                ferr_n = !rs;
                dout_n = rs ? sh : dout;
`ifdef UART_RX_PARITY_EN
                perr_n = par;
`endif
            end
            default: begin
                cnt_n = '0;
                state_n = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            sh <= '0;
            armed <= 1'b0;
            dout <= 8'h00;
            valid <= 1'b0;
            ferr <= 1'b0;
        end else begin
            sync <= {sync[0], rxd};
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            sh <= sh_n;
            armed <= armed_n;
            dout <= dout_n;
            valid <= valid_n;
            ferr <= ferr_n;
        end
    end
`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par <= 1'b0;
            perr <= 1'b0;
        end else begin
            par <= par_n;
            perr <= perr_n;
        end
    end
`else
    assign perr = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames checked against a frame-level timing model.
module tb_uart_rx;
    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
    localparam int NF = 11;
`else
    localparam int NB = 9;
    localparam int NF = 10;
`endif
    logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1;
    logic [7:0] dout;
    logic valid, ferr, perr;
    int cyc = 0, checks = 0, passes = 0;
    logic [7:0] last_good = 8'h00;
    typedef struct {int c; bit v; bit f; bit p; logic [7:0] d;} ev_t;
    ev_t got[$], expq[$];

    uart_rx #(.CLKS_PER_BIT(C)) dut (.clk(clk), .rst_n(rst_n), .rxd(rxd), .dout(dout),
        .valid(valid), .ferr(ferr), .perr(perr));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) if (valid || ferr || perr) begin
        got.push_back('{cyc, valid, ferr, perr, dout});
        check("valid_ferr_excl", {31'd0, valid & ferr}, 32'd0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // rst_at: frame bit index at which reset is pulsed mid-bit, -1 for none
    task automatic send(input logic [7:0] b, input bit stop, input bit par, input int rst_at);
        logic [10:0] bits;
        int e;
        bit p;
        e = cyc + 1;
`ifdef UART_RX_PARITY_EN
        bits = {stop, par, b, 1'b0};
        p = (^b) ^ par;
`else
        bits = {1'b0, stop, b, 1'b0};
        p = 1'b0;
`endif
        for (int i = 0; i < NF; i++) begin
            rxd = bits[i];
            if (i == rst_at) begin
                tick(C / 2);
                rst_n = 1'b0;
                #1;
                check("rst_dout", {24'd0, dout}, 32'd0);
                check("rst_valid", {31'd0, valid}, 32'd0);
                check("rst_ferr", {31'd0, ferr}, 32'd0);
                check("rst_perr", {31'd0, perr}, 32'd0);
                tick(3);
                rst_n = 1'b1;
                tick(C / 2 - 3);
            end else tick(C);
        end
        if (rst_at < 0) begin
            if (stop) last_good = b;
            expq.push_back('{e + 2 + C / 2 + NB * C, stop, !stop, p, last_good});
        end else last_good = 8'h00;
    endtask

    task automatic flush(input string tag);
        tick(8);
        check({tag, "_count"}, got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            check({tag, "_cyc"}, got[i].c, expq[i].c);
            check({tag, "_valid"}, {31'd0, got[i].v}, {31'd0, expq[i].v});
            check({tag, "_ferr"}, {31'd0, got[i].f}, {31'd0, expq[i].f});
            check({tag, "_perr"}, {31'd0, got[i].p}, {31'd0, expq[i].p});
            check({tag, "_dout"}, {24'd0, got[i].d}, {24'd0, expq[i].d});
        end
        got.delete();
        expq.delete();
    endtask

    initial begin
        bit st;
        int gap;
        tick(3);
        check("reset_dout", {24'd0, dout}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_ferr", {31'd0, ferr}, 32'd0);
        check("reset_perr", {31'd0, perr}, 32'd0);
        rst_n = 1'b1;
        tick(10);
        send(8'hA5, 1'b1, 1'b0, -1);
        flush("a5");
        tick(5);
        send(8'h3C, 1'b1, 1'b0, -1);
        send(8'hC3, 1'b1, 1'b1, -1);
        flush("b2b");
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(40);
        flush("glitch");
        check("glitch_dout", {24'd0, dout}, {24'd0, last_good});
        send(8'h55, 1'b0, 1'b0, -1);
        tick(100);
        rxd = 1'b1;
        tick(20);
        send(8'h0F, 1'b1, 1'b0, -1);
        flush("break");
        tick(5);
        send(8'hFF, 1'b1, 1'b0, 5);
        tick(20);
        send(8'h81, 1'b1, 1'b0, -1);
        flush("reset_mid");
`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b0, -1);
        send(8'h07, 1'b1, 1'b1, -1);
        flush("parity");
`endif
        for (int k = 0; k < 10; k++) begin
            st = ($urandom_range(0, 3) != 0);
            send(8'($urandom), st, 1'($urandom), -1);
            gap = $urandom_range(st ? 0 : 1, 20);
            rxd = 1'b1;
            tick(gap);
        end
        flush("random");
        check("final_dout", {24'd0, dout}, {24'd0, last_good});
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
